// File: rtl/picorv32_mem_pkg.sv
// Shared definitions for the PicoRV32 native-bus initiator: FSM encoding,
// strobe constants and error-reason codes.
package picorv32_mem_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_REQ     = 2'd1;
  localparam state_t ST_RELEASE = 2'd2;
  localparam state_t ST_RESP    = 2'd3;

  localparam logic [3:0] WSTRB_NONE = 4'b0000;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_WSTRB    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  // A command is rejected before touching the bus if it is not word aligned
  // or is a write that would change no bytes.
  function automatic logic cmd_is_bad(input logic [1:0] addr_lo,
                                      input logic       write,
                                      input logic [3:0] wstrb);
    return (addr_lo != 2'b00) || (write && (wstrb == WSTRB_NONE));
  endfunction

endpackage

// File: rtl/picorv32_mem_initiator.sv
// Single-outstanding valid/ready-to-PicoRV32 native memory bus initiator.
// Optional REQ timeout enabled by defining PICORV32_MEM_INITIATOR_TIMEOUT_EN.
module picorv32_mem_initiator
  import picorv32_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic                  cmd_instr,
  input  logic [31:0]           cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_valid,
  output logic                  mem_instr,
  input  logic                  mem_ready,
  output logic [31:0]           mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  state_t                r_state;
  logic                  r_write;
  logic                  r_busy;
  logic                  r_mem_valid;
  logic                  r_mem_instr;
  logic [31:0]           r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [3:0]            r_mem_wstrb;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;

  logic w_cmd_fire;
  logic w_cmd_bad;
  logic w_tmo_hit;

  assign cmd_ready  = resetn & (r_state == ST_IDLE);
  assign w_cmd_fire = cmd_valid & cmd_ready;
  assign w_cmd_bad  = cmd_is_bad(cmd_addr[1:0], cmd_write, cmd_wstrb);

`ifdef PICORV32_MEM_INITIATOR_TIMEOUT_EN
  logic [7:0] r_tmo_cnt;

  // Counter is zero outside REQ, so it is already clear on REQ entry.
  always_ff @(posedge clk) begin
    if (!resetn || (r_state != ST_REQ)) begin
      r_tmo_cnt <= 8'd0;
    end else if (!mem_ready) begin
      r_tmo_cnt <= r_tmo_cnt + 8'd1;
    end
  end

  assign w_tmo_hit = (r_tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] w_unused_tmo;
  assign w_unused_tmo = 32'(TIMEOUT_CYCLES);
  assign w_tmo_hit    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_write     <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_instr <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= WSTRB_NONE;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_fire) begin
            r_write <= cmd_write;
            r_busy  <= 1'b1;
            if (w_cmd_bad) begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
            end else begin
              r_state     <= ST_REQ;
              r_mem_valid <= 1'b1;
              r_mem_instr <= cmd_instr;
              r_mem_addr  <= cmd_addr;
              r_mem_wdata <= cmd_wdata;
              r_mem_wstrb <= cmd_write ? cmd_wstrb : WSTRB_NONE;
            end
          end
        end
        ST_REQ: begin
          // mem_ready takes priority over a timeout landing in the same cycle.
          if (mem_ready) begin
            r_rsp_rdata <= r_write ? '0 : mem_rdata;
            r_rsp_err   <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_wstrb <= WSTRB_NONE;
            r_state     <= ST_RELEASE;
          end else if (w_tmo_hit) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_mem_valid <= 1'b0;
            r_mem_wstrb <= WSTRB_NONE;
            r_state     <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          // The responder holds mem_ready until it sees mem_valid low.
          if (!mem_ready) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign mem_valid = r_mem_valid;
  assign mem_instr = r_mem_instr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;
  assign busy      = r_busy;

endmodule

// File: tb/tb_picorv32_mem_initiator.sv
// Directed bench for picorv32_mem_initiator: a vector table of commands
// against a small SRAM responder, plus reset and timeout sequences.
module tb_picorv32_mem_initiator;
  import picorv32_mem_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic        cmd_instr = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'hBAD0BAD0;
  logic        busy;

  always #5 clk = ~clk;

  picorv32_mem_initiator #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_instr(cmd_instr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // SRAM responder: answers rs_delay cycles after mem_valid, keeps mem_ready
  // high until mem_valid drops, then rs_hold further cycles.
  logic [31:0] rmem [16];
  int rs_delay = 0;
  int rs_hold = 0;
  int rs_cnt = 0;
  int rs_hcnt = 0;
  bit rs_sticky = 0;
  int rs_idx;

  always @(negedge clk) begin
    if (rs_sticky) begin
      if (rs_hcnt >= rs_hold) begin
        mem_ready = 1'b0;
        mem_rdata = 32'hBAD0BAD0;
        rs_sticky = 0;
      end else begin
        rs_hcnt++;
      end
    end else if (mem_ready) begin
      if (!mem_valid) begin
        if (rs_hold == 0) begin
          mem_ready = 1'b0;
          mem_rdata = 32'hBAD0BAD0;
        end else begin
          rs_sticky = 1;
          rs_hcnt = 1;
        end
      end
    end else if (mem_valid) begin
      if (rs_cnt >= rs_delay) begin
        rs_cnt = 0;
        rs_idx = int'(mem_addr[5:2]);
        mem_ready = 1'b1;
        mem_rdata = rmem[rs_idx];
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) rmem[rs_idx][8*b +: 8] = mem_wdata[8*b +: 8];
      end else begin
        rs_cnt++;
      end
    end else begin
      rs_cnt = 0;
    end
  end

  // Bus monitor: records each request and flags unstable or stale-ready starts.
  int rise_cnt = 0;
  int prot_err = 0;
  int hi_cnt = 0;
  bit prev_mv = 0;
  logic [3:0]  seen_wstrb = '0;
  logic [31:0] seen_addr = '0;
  logic [31:0] seen_wdata = '0;
  logic        seen_instr = 1'b0;

  always @(posedge clk) begin
    #1;
    if (mem_valid) begin
      if (!prev_mv) begin
        rise_cnt++;
        seen_wstrb = mem_wstrb;
        seen_addr  = mem_addr;
        seen_wdata = mem_wdata;
        seen_instr = mem_instr;
        hi_cnt = 0;
        if (mem_ready) prot_err++;
      end else if (mem_wstrb !== seen_wstrb || mem_addr !== seen_addr ||
                   mem_wdata !== seen_wdata || mem_instr !== seen_instr) begin
        prot_err++;
      end
      hi_cnt++;
    end
    prev_mv = mem_valid;
  end

  typedef struct {
    logic        wr;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          delay;
    int          hold;
    logic        rdy_hi;
    int          bp;
    logic [1:0]  reason;
    logic [31:0] exp_rdata;
  } vec_t;

  function automatic vec_t mkv(input logic wr, input logic instr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] wstrb,
                               input int delay, input int hold, input logic rdy_hi,
                               input int bp, input logic [1:0] reason,
                               input logic [31:0] exp_rdata);
    vec_t v;
    v.wr = wr; v.instr = instr; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
    v.delay = delay; v.hold = hold; v.rdy_hi = rdy_hi; v.bp = bp;
    v.reason = reason; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  task automatic run_vec(input vec_t v, input string tag);
    int   base_rise;
    int   base_prot;
    int   waited;
    logic exp_bus;
    exp_bus   = (v.reason == ERR_NONE);
    rs_delay  = v.delay;
    rs_hold   = v.hold;
    base_rise = rise_cnt;
    base_prot = prot_err;
    waited = 0;
    while (!cmd_ready && waited < 50) begin
      @(posedge clk); #1; waited++;
    end
    chk({tag, ".cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_instr = v.instr;
    cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
    rsp_ready = v.rdy_hi;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    chk({tag, ".mem_valid_1cyc"}, 32'(mem_valid), 32'(exp_bus));
    waited = 0;
    while (!rsp_valid && waited < 200) begin
      @(posedge clk); #1; waited++;
    end
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".rsp_rdata"}, rsp_rdata, v.exp_rdata);
    chk({tag, ".rsp_err"}, 32'(rsp_err), 32'(v.reason != ERR_NONE));
    chk({tag, ".bus_txns"}, 32'(rise_cnt - base_rise), 32'(exp_bus));
    chk({tag, ".protocol"}, 32'(prot_err - base_prot), 32'd0);
    if (exp_bus) begin
      chk({tag, ".mem_wstrb"}, 32'(seen_wstrb), 32'(v.wr ? v.wstrb : WSTRB_NONE));
      chk({tag, ".mem_addr"}, seen_addr, v.addr);
      chk({tag, ".mem_instr"}, 32'(seen_instr), 32'(v.instr));
    end
    for (int i = 0; i < v.bp; i++) begin
      @(posedge clk); #1;
      chk({tag, ".bp_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, ".bp_rdata"}, rsp_rdata, v.exp_rdata);
      chk({tag, ".bp_cmd_ready"}, 32'(cmd_ready), 32'd0);
    end
    if (!v.rdy_hi) rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, ".rsp_done"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".cmd_ready_after"}, 32'(cmd_ready), 32'd1);
    chk({tag, ".busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) rmem[i] = 32'h0;
    rmem[4] = 32'hDEADBEEF;
    rmem[8] = 32'hAABBCCDD;

    //              wr  in  addr          wdata         strb    dly hold rdyhi bp reason        rdata
    vecs[0]  = mkv(1'b0, 1'b0, 32'h0000_0010, 32'h0,         4'b0000, 3, 0, 1'b0, 0,  ERR_NONE,     32'hDEADBEEF);
    vecs[1]  = mkv(1'b1, 1'b0, 32'h0000_0020, 32'h11223344,  4'b0101, 2, 0, 1'b0, 0,  ERR_NONE,     32'h0);
    vecs[2]  = mkv(1'b0, 1'b0, 32'h0000_0020, 32'h0,         4'b1111, 0, 0, 1'b0, 0,  ERR_NONE,     32'hAA22CC44);
    vecs[3]  = mkv(1'b0, 1'b0, 32'h0000_0003, 32'h0,         4'b0000, 0, 0, 1'b0, 0,  ERR_MISALIGN, 32'h0);
    vecs[4]  = mkv(1'b1, 1'b0, 32'h0000_0024, 32'h12345678,  4'b0000, 0, 0, 1'b0, 0,  ERR_WSTRB,    32'h0);
    vecs[5]  = mkv(1'b1, 1'b0, 32'h0000_0022, 32'h12345678,  4'b1111, 0, 0, 1'b0, 0,  ERR_MISALIGN, 32'h0);
    vecs[6]  = mkv(1'b1, 1'b0, 32'h0000_0024, 32'hCAFEF00D,  4'b1111, 1, 4, 1'b0, 0,  ERR_NONE,     32'h0);
    vecs[7]  = mkv(1'b0, 1'b0, 32'h0000_0024, 32'h0,         4'b0000, 0, 4, 1'b0, 0,  ERR_NONE,     32'hCAFEF00D);
    vecs[8]  = mkv(1'b0, 1'b1, 32'h0000_0010, 32'h0,         4'b0000, 1, 0, 1'b1, 0,  ERR_NONE,     32'hDEADBEEF);
    vecs[9]  = mkv(1'b1, 1'b0, 32'h0000_0028, 32'h55667788,  4'b1000, 5, 0, 1'b0, 0,  ERR_NONE,     32'h0);
    vecs[10] = mkv(1'b0, 1'b0, 32'h0000_0028, 32'h0,         4'b0000, 0, 0, 1'b0, 0,  ERR_NONE,     32'h55000000);
    vecs[11] = mkv(1'b0, 1'b0, 32'h0000_0010, 32'h0,         4'b0000, 0, 0, 1'b0, 10, ERR_NONE,     32'hDEADBEEF);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst.mem_valid", 32'(mem_valid), 32'd0);
    chk("rst.mem_instr", 32'(mem_instr), 32'd0);
    chk("rst.mem_addr", mem_addr, 32'h0);
    chk("rst.mem_wdata", mem_wdata, 32'h0);
    chk("rst.mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.rsp_rdata", rsp_rdata, 32'h0);
    chk("rst.rsp_err", 32'(rsp_err), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset while a read is waiting in REQ: no response may follow.
    rs_delay = 20;
    rs_hold = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_instr = 1'b0;
    cmd_addr = 32'h0000_0014; cmd_wstrb = 4'b0000;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("rstreq.mem_valid_on", 32'(mem_valid), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("rstreq.mem_valid_off", 32'(mem_valid), 32'd0);
    chk("rstreq.busy", 32'(busy), 32'd0);
    chk("rstreq.cmd_ready_in_rst", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("rstreq.cmd_ready_after", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("rstreq.no_rsp", 32'(rsp_valid), 32'd0);
      chk("rstreq.no_bus", 32'(mem_valid), 32'd0);
    end

`ifdef PICORV32_MEM_INITIATOR_TIMEOUT_EN
    // Responder never answers: request is abandoned after 8 REQ cycles.
    begin
      int waited;
      rs_delay = 100000;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0018;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      waited = 0;
      while (mem_valid && waited < 50) begin
        @(posedge clk); #1; waited++;
      end
      chk("tmo.mem_valid_drop", 32'(mem_valid), 32'd0);
      chk("tmo.req_cycles", 32'(hi_cnt), 32'd8);
      waited = 0;
      while (!rsp_valid && waited < 50) begin
        @(posedge clk); #1; waited++;
      end
      chk("tmo.rsp_valid", 32'(rsp_valid), 32'd1);
      chk("tmo.rsp_err", 32'(rsp_err), 32'd1);
      chk("tmo.rsp_rdata", rsp_rdata, 32'h0);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("tmo.cmd_ready", 32'(cmd_ready), 32'd1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
